// File: rtl/spi_slave_param.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | spi_slave_param : clk-sampled SPI slave, {cmd[1:0], payload} frames, MSB  |
// | first. Optional macro SPI_SLAVE_FRAME_ERR_EN enables frame_err. Rev 1.0  |
// +--------------------------------------------------------------------------+
module spi_slave_param #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              rx_valid,
   output logic [DATA_W+1:0] rx_data,
   output logic              MISO,
   output logic              frame_err
);

   localparam int c_FRAME_W = DATA_W + 2;
   localparam int c_CNT_W   = $clog2(DATA_W + 1);
   localparam logic [c_CNT_W-1:0] c_RX_LAST = c_CNT_W'(DATA_W);
   localparam logic [c_CNT_W-1:0] c_TX_LAST = c_CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_CHK_CMD      = 3'd1,
      S_WRITE        = 3'd2,
      S_READ_ADD     = 3'd3,
      S_READ_DATA_RX = 3'd4,
      S_READ_DATA_TX = 3'd5,
      S_END          = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_armed;
   logic                 r_rd_addr_seen;
   logic                 r_tx_busy;
   logic                 r_rx_valid;
   logic                 r_miso;
   logic [c_CNT_W-1:0]   r_bit_cnt;
   logic [c_FRAME_W-2:0] r_rx_shift;
   logic [c_FRAME_W-1:0] r_rx_data;
   logic [DATA_W-1:0]    r_tx_shift;

   logic                 w_cmd_sample;
   logic                 w_shift;
   logic                 w_complete;
   logic                 w_abort;
   logic                 w_tx_load;
   logic                 w_tx_shift;
   logic                 w_tx_done;
   logic                 w_rd_set;
   logic                 w_rd_clr;
   logic [c_FRAME_W-1:0] w_rx_word;

   // Bits captured so far plus the one on the wire this cycle.
   assign w_rx_word = {r_rx_shift, MOSI};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cmd_sample = 1'b0;
      w_shift      = 1'b0;
      w_complete   = 1'b0;
      w_abort      = 1'b0;
      w_tx_load    = 1'b0;
      w_tx_shift   = 1'b0;
      w_tx_done    = 1'b0;
      w_rd_set     = 1'b0;
      w_rd_clr     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!SS_n && r_armed) begin
               w_state_nxt = S_CHK_CMD;
            end
         end
         S_CHK_CMD: begin
            if (SS_n) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cmd_sample = 1'b1;
               if (!MOSI) begin
                  w_state_nxt = S_WRITE;
               end else if (!r_rd_addr_seen) begin
                  w_state_nxt = S_READ_ADD;
               end else begin
                  w_state_nxt = S_READ_DATA_RX;
               end
            end
         end
         S_WRITE, S_READ_ADD, S_READ_DATA_RX: begin
            // The last bit completes even if SS_n rises on that same edge.
            if (r_bit_cnt == c_RX_LAST) begin
               w_shift    = 1'b1;
               w_complete = 1'b1;
               if (r_state == S_READ_DATA_RX) begin
                  w_rd_clr    = 1'b1;
                  w_state_nxt = S_READ_DATA_TX;
               end else begin
                  w_rd_set    = (r_state == S_READ_ADD);
                  w_state_nxt = S_END;
               end
            end else if (SS_n) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_shift = 1'b1;
            end
         end
         S_READ_DATA_TX: begin
            if (r_tx_busy && (r_bit_cnt == c_TX_LAST)) begin
               w_tx_done   = 1'b1;
               w_state_nxt = S_END;
            end else if (SS_n) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_tx_busy) begin
               w_tx_shift = 1'b1;
            end else if (tx_valid) begin
               w_tx_load = 1'b1;
            end
         end
         S_END: begin
            if (SS_n) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_armed        <= 1'b0;
         r_rd_addr_seen <= 1'b0;
         r_tx_busy      <= 1'b0;
         r_rx_valid     <= 1'b0;
         r_miso         <= 1'b0;
         r_bit_cnt      <= '0;
         r_rx_shift     <= '0;
         r_rx_data      <= '0;
         r_tx_shift     <= '0;
      end else begin
         // A frame may only start after SS_n has been seen high since reset.
         if (SS_n) begin
            r_armed <= 1'b1;
         end

         r_rx_valid <= w_complete;

         if (w_abort || w_cmd_sample || w_complete || w_tx_load || w_tx_done) begin
            r_bit_cnt <= '0;
         end else if (w_shift || w_tx_shift) begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
         end

         if (w_cmd_sample) begin
            r_rx_shift <= {{(c_FRAME_W-2){1'b0}}, MOSI};
         end else if (w_abort || w_complete) begin
            r_rx_shift <= '0;
         end else if (w_shift) begin
            r_rx_shift <= w_rx_word[c_FRAME_W-2:0];
         end

         if (w_complete) begin
            r_rx_data <= w_rx_word;
         end

         if (w_rd_set) begin
            r_rd_addr_seen <= 1'b1;
         end else if (w_rd_clr) begin
            r_rd_addr_seen <= 1'b0;
         end

         if (w_tx_load) begin
            r_miso     <= tx_data[DATA_W-1];
            r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
            r_tx_busy  <= 1'b1;
         end else if (w_tx_shift) begin
            r_miso     <= r_tx_shift[DATA_W-1];
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
         end else if (w_tx_done || w_abort) begin
            r_miso     <= 1'b0;
            r_tx_shift <= '0;
            r_tx_busy  <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic r_frame_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_abort;
      end
   end

   assign frame_err = r_frame_err;
`else
   assign frame_err = 1'b0;
`endif

   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign MISO     = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_spi_slave_param : self-checking bench for spi_slave_param, DATA_W=8.  |
// | Honours SPI_SLAVE_FRAME_ERR_EN for frame_err expectations. Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_spi_slave_param;

   localparam int DATA_W  = 8;
   localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               SS_n;
   logic               MOSI;
   logic               tx_valid;
   logic [DATA_W-1:0]  tx_data;
   logic               rx_valid;
   logic [FRAME_W-1:0] rx_data;
   logic               MISO;
   logic               frame_err;

   int                 n_assert = 0;
   int                 n_fail   = 0;
   bit                 model_seen;
   logic [FRAME_W-1:0] model_rx;

   always #5 clk = ~clk;

   spi_slave_param #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .MISO      (MISO),
      .frame_err (frame_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Ends the current frame early, either by deselect or by a one-edge reset.
   task automatic stop_frame(input bit by_reset);
      if (by_reset) begin
         rst_n = 1'b0;
         tick();
         rst_n      = 1'b1;
         model_seen = 1'b0;
         model_rx   = '0;
         chk1("rst_miso", MISO, 1'b0);
         chk1("rst_rxv", rx_valid, 1'b0);
         chk1("rst_ferr", frame_err, 1'b0);
         chkw("rst_rxd", rx_data, model_rx);
      end else begin
         SS_n = 1'b1;
         tick();
         chk1("abort_ferr", frame_err, FE_EN);
         chk1("abort_miso", MISO, 1'b0);
         chk1("abort_rxv", rx_valid, 1'b0);
         chkw("abort_rxd", rx_data, model_rx);
         tick();
         chk1("abort_ferr_once", frame_err, 1'b0);
      end
   endtask

   // tx_stop: -1 run to completion, 0 stop while waiting for tx_valid,
   // n>0 stop after n reply bits have been presented.
   task automatic run_frame(input logic [1:0] cmd, input logic [DATA_W-1:0] payload,
                            input int extra_low, input bit late_ss, input int wait_k,
                            input logic [DATA_W-1:0] reply, input int tx_stop,
                            input bit stop_by_reset);
      logic [FRAME_W-1:0] word;
      logic [DATA_W-1:0]  rep;
      bit                 rd_data;
      word    = {cmd, payload};
      rep     = reply;
      // A read with an address already captured is the data phase and
      // consumes it; any other read is an address phase.
      rd_data = cmd[1] & model_seen;
      if (cmd[1]) model_seen = ~model_seen;

      SS_n     = 1'b0;
      MOSI     = 1'($urandom);
      tx_valid = 1'($urandom);
      tick();
      chk1("start_rxv", rx_valid, 1'b0);
      for (int i = 0; i < FRAME_W; i++) begin
         MOSI     = word[FRAME_W-1];
         word     = word << 1;
         tx_valid = 1'($urandom);
         tx_data  = DATA_W'($urandom);
         if (late_ss && i == FRAME_W - 1) SS_n = 1'b1;
         tick();
         chk1("rx_miso", MISO, 1'b0);
         if (i < FRAME_W - 1) chk1("rx_valid_early", rx_valid, 1'b0);
      end
      model_rx = {cmd, payload};
      chk1("rx_valid_pulse", rx_valid, 1'b1);
      chkw("rx_data", rx_data, model_rx);
      chk1("rx_ferr", frame_err, 1'b0);

      if (rd_data) begin
         tx_valid = 1'b0;
         for (int k = 0; k < wait_k; k++) begin
            tick();
            chk1("wait_rxv", rx_valid, 1'b0);
            chk1("wait_miso", MISO, 1'b0);
         end
         if (tx_stop == 0) begin
            stop_frame(stop_by_reset);
            return;
         end
         tx_valid = 1'b1;
         tx_data  = reply;
         tick();
         tx_valid = 1'($urandom);
         tx_data  = DATA_W'($urandom);
         chk1("latch_rxv", rx_valid, 1'b0);
         for (int j = 0; j < DATA_W; j++) begin
            if (j == tx_stop) begin
               stop_frame(stop_by_reset);
               return;
            end
            chk1("miso_bit", MISO, rep[DATA_W-1]);
            rep = rep << 1;
            tick();
         end
         chk1("miso_tail", MISO, 1'b0);
      end else begin
         // A reply offered here must be ignored.
         tx_valid = 1'b1;
         tx_data  = '1;
         tick();
         chk1("rxv_once", rx_valid, 1'b0);
         chk1("end_miso", MISO, 1'b0);
         for (int k = 0; k < extra_low; k++) begin
            MOSI = 1'($urandom);
            tick();
            chk1("end_rxv", rx_valid, 1'b0);
            chk1("end_hold_miso", MISO, 1'b0);
         end
      end
      SS_n     = 1'b1;
      tx_valid = 1'b0;
      tick();
      chk1("idle_miso", MISO, 1'b0);
      chk1("idle_ferr", frame_err, 1'b0);
      chk1("idle_rxv", rx_valid, 1'b0);
      chkw("idle_rxd", rx_data, model_rx);
   endtask

   task automatic abort_frame(input logic [1:0] cmd, input int nbits);
      logic [FRAME_W-1:0] word;
      word     = {cmd, DATA_W'($urandom)};
      SS_n     = 1'b0;
      tx_valid = 1'($urandom);
      tick();
      for (int i = 0; i < nbits; i++) begin
         MOSI = word[FRAME_W-1];
         word = word << 1;
         tick();
         chk1("part_rxv", rx_valid, 1'b0);
      end
      stop_frame(1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      SS_n       = 1'b1;
      MOSI       = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = '0;
      model_seen = 1'b0;
      model_rx   = '0;
      repeat (3) tick();
      chk1("reset_rxv", rx_valid, 1'b0);
      chkw("reset_rxd", rx_data, model_rx);
      chk1("reset_miso", MISO, 1'b0);
      chk1("reset_ferr", frame_err, 1'b0);
      rst_n = 1'b1;
      tick();

      // Directed frames: write, read address, read data with 0xC3 reply.
      run_frame(2'b00, 8'hA5, 0, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b10, 8'h10, 2, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b11, DATA_W'($urandom), 0, 1'b0, 5, 8'hC3, -1, 1'b0);

      // Deselect after 4 payload bits, then long END hold, then late deselect.
      abort_frame(2'b00, 6);
      run_frame(2'b00, DATA_W'($urandom), 4, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b00, DATA_W'($urandom), 0, 1'b1, 0, 8'h00, -1, 1'b0);

      // Aborts in command bit, near frame end, reply wait and reply shift.
      abort_frame(2'($urandom), 0);
      abort_frame(2'b10, FRAME_W - 2);
      run_frame(2'b10, DATA_W'($urandom), 0, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b11, DATA_W'($urandom), 0, 1'b0, 3, 8'h5A, 0, 1'b0);
      run_frame(2'b10, DATA_W'($urandom), 0, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b11, DATA_W'($urandom), 0, 1'b0, 1, 8'hFF, 3, 1'b0);

      for (int n = 0; n < 24; n++) begin
         run_frame(2'($urandom), DATA_W'($urandom), int'($urandom_range(0, 3)), 1'b0,
                   int'($urandom_range(0, 6)), DATA_W'($urandom), -1, 1'b0);
         if ($urandom_range(0, 3) == 0) abort_frame(2'($urandom), int'($urandom_range(0, FRAME_W - 2)));
      end

      // Reset while an address is pending forgets it.
      if (!model_seen) run_frame(2'b10, DATA_W'($urandom), 0, 1'b0, 0, 8'h00, -1, 1'b0);
      stop_frame(1'b1);
      tick();
      run_frame(2'b11, DATA_W'($urandom), 2, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b10, DATA_W'($urandom), 0, 1'b0, 2, DATA_W'($urandom), -1, 1'b0);

      // Reset in the middle of a reply, with SS_n left low afterwards.
      if (!model_seen) run_frame(2'b10, DATA_W'($urandom), 0, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b11, DATA_W'($urandom), 0, 1'b0, 2, 8'hB6, 4, 1'b1);
      for (int k = 0; k < FRAME_W + 4; k++) begin
         MOSI     = 1'($urandom);
         tx_valid = 1'($urandom);
         tick();
         chk1("hold_rxv", rx_valid, 1'b0);
         chk1("hold_miso", MISO, 1'b0);
         chk1("hold_ferr", frame_err, 1'b0);
      end
      SS_n = 1'b1;
      tick();
      run_frame(2'b11, DATA_W'($urandom), 1, 1'b0, 0, 8'h00, -1, 1'b0);
      run_frame(2'b11, DATA_W'($urandom), 0, 1'b0, 0, DATA_W'($urandom), -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
